// File: rtl/mips_alu_pkg.sv
// Shared ALU control definitions: ALU op codes, opcode/funct constants,
// operand select encodings and the decoded-instruction bundle.
package mips_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLL  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SRA  = 4'h8;
  localparam logic [3:0] ALU_UCMP = 4'h9;
  localparam logic [3:0] ALU_SCMP = 4'hA;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    SRC1_RS      = 2'd0,
    SRC1_SHAMT   = 2'd1,
    SRC1_CONST16 = 2'd2
  } src1_sel_e;

  typedef enum logic {
    SRC2_RT  = 1'b0,
    SRC2_IMM = 1'b1
  } src2_sel_e;

  typedef struct packed {
    logic [3:0]  aluOp;
    src1_sel_e   src1Sel;
    src2_sel_e   src2Sel;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regWrite;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode into ALU control fields.
// Variable shifts (sllv/srlv/srav) decode only when ALU_VSHIFT_EN is defined.
module alu_op_decode
  import mips_alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [31:0] w_immSext;
  logic [31:0] w_immZext;

  assign w_op      = i_instr[31:26];
  assign w_funct   = i_instr[5:0];
  assign w_immSext = {{16{i_instr[15]}}, i_instr[15:0]};
  assign w_immZext = {16'h0000, i_instr[15:0]};

  // Start from the illegal-encoding result so every unmatched case falls back to it.
  always_comb begin
    o_dec.aluOp    = ALU_ADD;
    o_dec.src1Sel  = SRC1_RS;
    o_dec.src2Sel  = SRC2_RT;
    o_dec.imm      = w_immSext;
    o_dec.rd       = i_instr[20:16];
    o_dec.regWrite = 1'b0;
    o_dec.illegal  = 1'b1;
    case (w_op)
      OP_RTYPE: begin
        o_dec.rd       = i_instr[15:11];
        o_dec.regWrite = 1'b1;
        o_dec.illegal  = 1'b0;
        case (w_funct)
          FN_ADD, FN_ADDU: o_dec.aluOp = ALU_ADD;
          FN_SUB, FN_SUBU: o_dec.aluOp = ALU_SUB;
          FN_AND:          o_dec.aluOp = ALU_AND;
          FN_OR:           o_dec.aluOp = ALU_OR;
          FN_XOR:          o_dec.aluOp = ALU_XOR;
          FN_NOR:          o_dec.aluOp = ALU_NOR;
          FN_SLT:          o_dec.aluOp = ALU_SCMP;
          FN_SLTU:         o_dec.aluOp = ALU_UCMP;
          FN_SLL: begin
            o_dec.aluOp   = ALU_SLL;
            o_dec.src1Sel = SRC1_SHAMT;
          end
          FN_SRL: begin
            o_dec.aluOp   = ALU_SRL;
            o_dec.src1Sel = SRC1_SHAMT;
          end
          FN_SRA: begin
            o_dec.aluOp   = ALU_SRA;
            o_dec.src1Sel = SRC1_SHAMT;
          end
          FN_JR:           o_dec.regWrite = 1'b0;
`ifdef ALU_VSHIFT_EN
          FN_SLLV:         o_dec.aluOp = ALU_SLL;
          FN_SRLV:         o_dec.aluOp = ALU_SRL;
          FN_SRAV:         o_dec.aluOp = ALU_SRA;
`endif
          default: begin
            o_dec.regWrite = 1'b0;
            o_dec.illegal  = 1'b1;
          end
        endcase
      end
      OP_BEQ, OP_BNE: begin
        o_dec.aluOp   = ALU_SUB;
        o_dec.illegal = 1'b0;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
        o_dec.src2Sel  = SRC2_IMM;
        o_dec.regWrite = (w_op != OP_SW);
        o_dec.illegal  = 1'b0;
        if (w_op == OP_SLTI)
          o_dec.aluOp = ALU_SCMP;
        else if (w_op == OP_SLTIU)
          o_dec.aluOp = ALU_UCMP;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        o_dec.src2Sel  = SRC2_IMM;
        o_dec.imm      = w_immZext;
        o_dec.regWrite = 1'b1;
        o_dec.illegal  = 1'b0;
        case (w_op)
          OP_ANDI: o_dec.aluOp = ALU_AND;
          OP_ORI:  o_dec.aluOp = ALU_OR;
          OP_XORI: o_dec.aluOp = ALU_XOR;
          default: begin
            o_dec.aluOp   = ALU_SLL;
            o_dec.src1Sel = SRC1_CONST16;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX pipeline register for ALU control plus saturating illegal-instruction counter.
// Optional variable-shift decode is enabled by defining ALU_VSHIFT_EN.
module alu_ctrl_stage
  import mips_alu_pkg::*;
#(
  parameter int ALUOP_W   = 4,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [31:0]          id_instr,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [ALUOP_W-1:0]   ex_alu_op,
  output logic [1:0]           ex_src1_sel,
  output logic                 ex_src2_sel,
  output logic [31:0]          ex_imm,
  output logic [4:0]           ex_shamt,
  output logic [4:0]           ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  dec_t                 w_dec;
  logic                 w_illAccept;

  logic                 r_valid;
  logic [ALUOP_W-1:0]   r_aluOp;
  logic [1:0]           r_src1Sel;
  logic                 r_src2Sel;
  logic [31:0]          r_imm;
  logic [4:0]           r_shamt;
  logic [4:0]           r_rd;
  logic                 r_regWrite;
  logic                 r_illegal;
  logic [ILL_CNT_W-1:0] r_illCount;

  alu_op_decode u_decode (
    .i_instr (id_instr),
    .o_dec   (w_dec)
  );

  assign w_illAccept = id_valid & w_dec.illegal & ~stall & ~flush;

  // Flush only kills the control bits that matter downstream; data fields keep their old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_aluOp    <= '0;
      r_src1Sel  <= 2'd0;
      r_src2Sel  <= 1'b0;
      r_imm      <= 32'd0;
      r_shamt    <= 5'd0;
      r_rd       <= 5'd0;
      r_regWrite <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (!stall) begin
      r_valid    <= id_valid;
      r_aluOp    <= ALUOP_W'(w_dec.aluOp);
      r_src1Sel  <= w_dec.src1Sel;
      r_src2Sel  <= w_dec.src2Sel;
      r_imm      <= w_dec.imm;
      r_shamt    <= id_instr[10:6];
      r_rd       <= w_dec.rd;
      r_regWrite <= id_valid & w_dec.regWrite;
      r_illegal  <= id_valid & w_dec.illegal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_illCount <= '0;
    else if (w_illAccept && (r_illCount != {ILL_CNT_W{1'b1}}))
      r_illCount <= r_illCount + 1'b1;
  end

  assign ex_valid     = r_valid;
  assign ex_alu_op    = r_aluOp;
  assign ex_src1_sel  = r_src1Sel;
  assign ex_src2_sel  = r_src2Sel;
  assign ex_imm       = r_imm;
  assign ex_shamt     = r_shamt;
  assign ex_rd        = r_rd;
  assign ex_reg_write = r_regWrite;
  assign ex_illegal   = r_illegal;
  assign ill_count    = r_illCount;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: driver pushes model expectations, monitor checks each cycle.
// Build with ALU_VSHIFT_EN defined to exercise the variable-shift decode.
module tb_alu_ctrl_stage;

  typedef struct {
    logic        valid;
    logic        regWrite;
    logic        illegal;
    int          cnt;
    logic [3:0]  aluOp;
    logic [1:0]  s1;
    logic        s2;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    bit          opKnown;
    bit          srcKnown;
    bit          immKnown;
    bit          rdKnown;
    bit          shamtKnown;
  } exp_t;

  logic        clk;
  logic        resetN;
  logic        idValid;
  logic [31:0] idInstr;
  logic        stall;
  logic        flush;
  logic        exValid;
  logic [3:0]  exAluOp;
  logic [1:0]  exSrc1;
  logic        exSrc2;
  logic [31:0] exImm;
  logic [4:0]  exShamt;
  logic [4:0]  exRd;
  logic        exRegWrite;
  logic        exIllegal;
  logic [7:0]  illCount;

  int   checks = 0;
  int   failures = 0;
  exp_t model;
  exp_t sbQ[$];

  alu_ctrl_stage #(.ALUOP_W(4), .ILL_CNT_W(8)) dut (
    .clk          (clk),
    .reset        (resetN),
    .id_valid     (idValid),
    .id_instr     (idInstr),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (exValid),
    .ex_alu_op    (exAluOp),
    .ex_src1_sel  (exSrc1),
    .ex_src2_sel  (exSrc2),
    .ex_imm       (exImm),
    .ex_shamt     (exShamt),
    .ex_rd        (exRd),
    .ex_reg_write (exRegWrite),
    .ex_illegal   (exIllegal),
    .ill_count    (illCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set table.
  function automatic exp_t refDecode(input logic [31:0] ins);
    exp_t e;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic [31:0] sImm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] zImm = {16'h0, ins[15:0]};
    e = '{valid: 1'b1, regWrite: 1'b0, illegal: 1'b0, cnt: 0, aluOp: 4'h0, s1: 2'd0, s2: 1'b0,
          imm: 32'h0, shamt: ins[10:6], rd: 5'h0, opKnown: 1, srcKnown: 1, immKnown: 0,
          rdKnown: 0, shamtKnown: 1};
    if (op == 6'h00) begin
      e.rd = ins[15:11]; e.rdKnown = 1; e.regWrite = 1'b1;
      case (fn)
        6'h20, 6'h21: e.aluOp = 4'h0;
        6'h22, 6'h23: e.aluOp = 4'h1;
        6'h24: e.aluOp = 4'h2;
        6'h25: e.aluOp = 4'h3;
        6'h26: e.aluOp = 4'h4;
        6'h27: e.aluOp = 4'h5;
        6'h2A: e.aluOp = 4'hA;
        6'h2B: e.aluOp = 4'h9;
        6'h00: begin e.aluOp = 4'h6; e.s1 = 2'd1; end
        6'h02: begin e.aluOp = 4'h7; e.s1 = 2'd1; end
        6'h03: begin e.aluOp = 4'h8; e.s1 = 2'd1; end
        6'h08: begin e.aluOp = 4'h0; e.regWrite = 1'b0; end
`ifdef ALU_VSHIFT_EN
        6'h04: e.aluOp = 4'h6;
        6'h06: e.aluOp = 4'h7;
        6'h07: e.aluOp = 4'h8;
`endif
        default: e.illegal = 1'b1;
      endcase
    end else if (op == 6'h04 || op == 6'h05) begin
      e.aluOp = 4'h1;
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B}) begin
      e.s2 = 1'b1; e.imm = sImm; e.immKnown = 1; e.rd = ins[20:16]; e.rdKnown = 1;
      e.regWrite = (op != 6'h2B);
      e.aluOp = (op == 6'h0A) ? 4'hA : (op == 6'h0B) ? 4'h9 : 4'h0;
    end else if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
      e.s2 = 1'b1; e.imm = zImm; e.immKnown = 1; e.rd = ins[20:16]; e.rdKnown = 1;
      e.regWrite = 1'b1;
      case (op)
        6'h0C: e.aluOp = 4'h2;
        6'h0D: e.aluOp = 4'h3;
        6'h0E: e.aluOp = 4'h4;
        default: begin e.aluOp = 4'h6; e.s1 = 2'd2; end
      endcase
    end else begin
      e.illegal = 1'b1;
    end
    if (e.illegal) begin
      e.regWrite = 1'b0; e.aluOp = 4'h0;
      e.srcKnown = 0; e.immKnown = 0; e.rdKnown = 0;
    end
    return e;
  endfunction

  function automatic exp_t resetModel();
    exp_t e;
    e = '{valid: 0, regWrite: 0, illegal: 0, cnt: 0, aluOp: 0, s1: 0, s2: 0, imm: 0,
          shamt: 0, rd: 0, opKnown: 1, srcKnown: 1, immKnown: 1, rdKnown: 1, shamtKnown: 1};
    return e;
  endfunction

  // One pipeline cycle: drive inputs, advance the model, and queue the expectation for after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    exp_t d;
    int   c;
    @(negedge clk);
    #1;
    idValid = v; idInstr = ins; stall = st; flush = fl;
    c = model.cnt;
    if (fl) begin
      model.valid = 0; model.regWrite = 0; model.illegal = 0;
      model.opKnown = 0; model.srcKnown = 0; model.immKnown = 0;
      model.rdKnown = 0; model.shamtKnown = 0;
    end else if (!st) begin
      if (v) begin
        d = refDecode(ins);
        if (d.illegal && c < 255) c++;
        model = d;
      end else begin
        model.valid = 0; model.regWrite = 0; model.illegal = 0;
        model.opKnown = 0; model.srcKnown = 0; model.immKnown = 0;
        model.rdKnown = 0; model.shamtKnown = 0;
      end
    end
    model.cnt = c;
    @(posedge clk);
    sbQ.push_back(model);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(exValid), 32'd0);
    checkOutput({tag, "_aluop"}, 32'(exAluOp), 32'd0);
    checkOutput({tag, "_src1"}, 32'(exSrc1), 32'd0);
    checkOutput({tag, "_src2"}, 32'(exSrc2), 32'd0);
    checkOutput({tag, "_imm"}, exImm, 32'd0);
    checkOutput({tag, "_shamt"}, 32'(exShamt), 32'd0);
    checkOutput({tag, "_rd"}, 32'(exRd), 32'd0);
    checkOutput({tag, "_regwr"}, 32'(exRegWrite), 32'd0);
    checkOutput({tag, "_illegal"}, 32'(exIllegal), 32'd0);
    checkOutput({tag, "_illcnt"}, 32'(illCount), 32'd0);
  endtask

  // Asynchronous reset asserted away from any clock edge; outputs must clear without a clock.
  task automatic doReset(input string tag);
    @(negedge clk);
    #1;
    resetN = 1'b0;
    #1;
    checkAllZero(tag);
    model = resetModel();
    @(negedge clk);
    #1;
    resetN = 1'b1;
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] ops[15] = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fns[18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                            6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h04, 6'h06, 6'h07, 6'h01};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 16);
    if (k < 15) w[31:26] = ops[k];
    else if (k == 15) w[31:26] = 6'h3F;
    if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0) w[5:0] = fns[$urandom_range(0, 17)];
    return w;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("valid", 32'(exValid), 32'(e.valid));
      checkOutput("reg_write", 32'(exRegWrite), 32'(e.regWrite));
      checkOutput("illegal", 32'(exIllegal), 32'(e.illegal));
      checkOutput("ill_count", 32'(illCount), 32'(e.cnt));
      if (e.opKnown) checkOutput("alu_op", 32'(exAluOp), 32'(e.aluOp));
      if (e.srcKnown) begin
        checkOutput("src1_sel", 32'(exSrc1), 32'(e.s1));
        checkOutput("src2_sel", 32'(exSrc2), 32'(e.s2));
      end
      if (e.immKnown) checkOutput("imm", exImm, e.imm);
      if (e.rdKnown) checkOutput("rd", 32'(exRd), 32'(e.rd));
      if (e.shamtKnown) checkOutput("shamt", 32'(exShamt), 32'(e.shamt));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0; idValid = 1'b0; idInstr = 32'h0; stall = 1'b0; flush = 1'b0;
    model = resetModel();
    #3;
    checkAllZero("por");
    repeat (2) @(negedge clk);
    #1;
    resetN = 1'b1;

    applyStimulus(1, 32'h012A4020, 0, 0);
    applyStimulus(1, 32'h34C58001, 0, 0);
    applyStimulus(1, 32'h28C58001, 0, 0);
    applyStimulus(1, 32'h3C031234, 0, 0);

    applyStimulus(1, 32'h012A4020, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h34C58001 + i, 1, 0);
    applyStimulus(1, 32'h3C031234, 1, 1);
    applyStimulus(0, 32'h012A4020, 0, 0);

    for (int i = 0; i < 300; i++) applyStimulus(1, {6'h3F, 26'($urandom)}, 0, 0);
    applyStimulus(1, 32'hFC000000, 1, 0);
    applyStimulus(1, 32'hFC000000, 0, 1);
    doReset("midrst");

    applyStimulus(1, 32'h012A4004, 0, 0);
    applyStimulus(1, 32'h012A4006, 0, 0);
    applyStimulus(1, 32'h012A4007, 0, 0);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) != 0, randInstr(),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge clk);
    if (sbQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d expected=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
